fixed_pow_unit: RTL and testbench
=================================

// Module: fixed_pow_unit
// PURPOSE
//  Sequential fixed-point power unit computing out = base^exp. It is the inverse
//  companion of the k-th root block: it raises a Q10.10 value to an integer power.
//  It produces golden forward values for root checking and serves datapaths that
//  need x^k. One shared multiplier runs one multiply per cycle, so latency is fixed.
// PARAMETERS
//  W      20  data width of base and result (unsigned fixed point)
//  FRAC   10  fractional bits (Q(W-FRAC).FRAC); 1.0 = 1<<FRAC
//  EXP_W   3  exponent width; legal exp 0..(2^EXP_W-1)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  in_valid   in   1      one-cycle request strobe; sampled only in IDLE
//  in_base    in   W      unsigned Q10.10 base
//  in_exp     in   EXP_W  unsigned integer exponent
//  out_valid  out  1      one-cycle result strobe
//  out_data   out  W      Q10.10 result; 0 whenever out_valid=0
//  out_ovf    out  1      result saturated; 0 whenever out_valid=0
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; out_valid=0, out_data=0, out_ovf=0.
//  Internal acc, base_r, cnt and ovf registers are cleared. Reset mid-operation
//  aborts the transaction and emits no result.
//  FSM IDLE -> CALC -> OUT -> IDLE:
//   IDLE: on in_valid=1, set base_r<=in_base and ovf<=0.
//     exp=0: acc<=ONE (20'h00400), cnt<=0. exp>=1: acc<=in_base, cnt<=exp-1.
//     Next state is CALC. If in_valid=0, stay in IDLE.
//   CALC: if cnt!=0, cnt<=cnt-1 and acc<=mul_sat(acc,base_r) (held if ovf=1).
//     If cnt==0, out_data<=acc, out_ovf<=ovf, out_valid<=1, and go to OUT.
//   OUT: out_valid<=0, out_data<=0, out_ovf<=0, and go to IDLE.
//  Latency: the request is sampled at edge E0. out_valid goes high after edge
//  E0+max(exp,1) and stays high exactly one cycle. Back-to-back is allowed:
//  a new in_valid is accepted in the cycle after out_valid falls (IDLE).
//  in_valid while in CALC or OUT is ignored (dropped, no queueing).
//  in_base and in_exp need to be stable only in the in_valid cycle.
//  mul_sat(a,b): p = a*b (2W bits, Q20.20); t = p>>FRAC (truncate, floor).
//   If t[2W-FRAC-1:W] != 0: result = {W{1'b1}} (20'hFFFFF) and ovf<=1 (sticky).
//   Otherwise result = t[W-1:0].
//   While ovf=1, acc is held saturated and later multiplies are skipped.
//   The cnt countdown continues, so latency does not depend on overflow.
//  Boundary cases:
//   base=0 with exp>=1 gives 0. base=0 with exp=0 gives 1.0.
//   base=20'hFFFFF with exp=1 gives 20'hFFFFF and ovf=0 (no multiply done).
//   Results below 2^-10 truncate to 0 and ovf stays 0.
// STRUCTURE
//  Shared package pow_pkg:
//   state typedef {IDLE, CALC, OUT}.
//   Constants FIX_W=20, FIX_FRAC=10, FIX_ONE=20'h00400, FIX_SAT=20'hFFFFF.
//  One sub-module fixed_mul_sat (combinational, params W/FRAC):
//   ports a, b -> p, ovf. It is reused by the divide/root datapaths.
//  The top level holds the FSM, the cnt down-counter, the acc/base_r/ovf
//  registers and the output registers.
// TESTING
//  1 base=20'h00800 (2.0), exp=3 -> out_data=20'h02000, ovf=0, out_valid at E0+3.
//  2 base=20'h12345, exp=0 -> out_data=20'h00400 at E0+1; exp=1 -> 20'h12345 at E0+1.
//  3 base=20'h00200 (0.5), exp=7 -> 20'h00008.
//    base=20'h00401, exp=2 -> 20'h00402 (truncation check).
//  4 base=20'h04000 (16.0), exp=3 -> 20'hFFFFF, out_ovf=1, out_valid still at E0+3.
//    Then base=20'h00400, exp=7 -> 20'h00400, ovf=0 (sticky flag cleared per request).
//  5 Pulse in_valid (base=2.0, exp=2) during CALC -> ignored, only the first
//    result appears. Back-to-back requests -> two pulses, each one cycle long.
//  6 rst_n=0 for one edge mid-CALC (exp=7) -> no out_valid, all outputs 0.
//    The next request (3.0^2) -> 20'h02400 with normal latency.

Source files
------------

// File: rtl/pow_pkg.sv
// pow_pkg: shared types and Q10.10 constants for the fixed-point power/root datapaths.
`default_nettype none

package pow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int              FIX_W    = 20;
  localparam int              FIX_FRAC = 10;
  localparam logic [FIX_W-1:0] FIX_ONE = 20'h00400;
  localparam logic [FIX_W-1:0] FIX_SAT = 20'hFFFFF;

endpackage

`default_nettype wire

// File: rtl/fixed_mul_sat.sv
// fixed_mul_sat: combinational unsigned fixed-point multiply, floor-truncated, saturating.
`default_nettype none

module fixed_mul_sat #(
  parameter int W    = 20,
  parameter int FRAC = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p,
  output logic         ovf
);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] shifted;

  assign prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign shifted = prod >> FRAC;

  // Top FRAC bits of shifted are always zero, so the OR covers the true integer overflow.
  assign ovf = |shifted[2*W-1:W];
  assign p   = ovf ? {W{1'b1}} : shifted[W-1:0];

endmodule

`default_nettype wire

// File: rtl/fixed_pow_unit.sv
// fixed_pow_unit: sequential base^exp in unsigned Q10.10, one shared multiply per cycle.
`default_nettype none

module fixed_pow_unit
  import pow_pkg::*;
#(
  parameter int W     = FIX_W,
  parameter int FRAC  = FIX_FRAC,
  parameter int EXP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_base,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_ovf
);

  state_t           state, state_nxt;
  logic [W-1:0]     acc, acc_nxt;
  logic [W-1:0]     base_r, base_nxt;
  logic [EXP_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             out_valid_nxt;
  logic [W-1:0]     out_data_nxt;
  logic             out_ovf_nxt;

  logic [W-1:0]     mul_p;
  logic             mul_ovf;

  fixed_mul_sat #(
    .W    (W),
    .FRAC (FRAC)
  ) u_mul (
    .a   (acc),
    .b   (base_r),
    .p   (mul_p),
    .ovf (mul_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      base_r    <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      base_r    <= base_nxt;
      cnt       <= cnt_nxt;
      ovf       <= ovf_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_ovf   <= out_ovf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    base_nxt      = base_r;
    cnt_nxt       = cnt;
    ovf_nxt       = ovf;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_ovf_nxt   = out_ovf;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          base_nxt  = in_base;
          ovf_nxt   = 1'b0;
          state_nxt = CALC;
          if (in_exp == '0) begin
            acc_nxt = FIX_ONE;
            cnt_nxt = '0;
          end else begin
            acc_nxt = in_base;
            cnt_nxt = in_exp - EXP_W'(1);
          end
        end
      end
      CALC: begin
        if (cnt != '0) begin
          // Countdown runs even when saturated so latency stays fixed.
          cnt_nxt = cnt - EXP_W'(1);
          if (!ovf) begin
            acc_nxt = mul_p;
            ovf_nxt = mul_ovf;
          end
        end else begin
          out_data_nxt  = acc;
          out_ovf_nxt   = ovf;
          out_valid_nxt = 1'b1;
          state_nxt     = OUT;
        end
      end
      OUT: begin
        out_valid_nxt = 1'b0;
        out_data_nxt  = '0;
        out_ovf_nxt   = 1'b0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_pow_unit.sv
// tb_fixed_pow_unit: directed self-checking bench for fixed_pow_unit.
`default_nettype none

module tb_fixed_pow_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_base = '0;
  logic [2:0]  in_exp = '0;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fixed_pow_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_base   (in_base),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called one step after a rising edge with the DUT in IDLE; returns in IDLE.
  task automatic do_req(input string tag, input logic [19:0] base, input logic [2:0] e,
                        input logic [19:0] exp_data, input logic exp_ovf, input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    in_valid = 1'b1;
    in_base  = base;
    in_exp   = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_base  = 20'h5A5A5;
    in_exp   = 3'd5;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat = i + 1;
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    check({tag, ".seen"}, 32'(seen), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".data"}, 32'(out_data), 32'(exp_data));
    check({tag, ".ovf"}, 32'(out_ovf), 32'(exp_ovf));
    @(posedge clk);
    #1;
    check({tag, ".fall"}, {11'd0, out_valid, out_data}, 32'd0);
  endtask

  initial begin
    int pulses;
    int first_at;
    logic [19:0] first_data;

    repeat (3) @(posedge clk);
    #1;
    check("reset.outs", {11'd0, out_valid, out_ovf, out_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle.outs", {11'd0, out_valid, out_ovf, out_data}, 32'd0);

    do_req("t1.2p3",   20'h00800, 3'd3, 20'h02000, 1'b0, 3);
    do_req("t2.e0",    20'h12345, 3'd0, 20'h00400, 1'b0, 1);
    do_req("t2.e1",    20'h12345, 3'd1, 20'h12345, 1'b0, 1);
    do_req("t3.half7", 20'h00200, 3'd7, 20'h00008, 1'b0, 7);
    do_req("t3.trunc", 20'h00401, 3'd2, 20'h00402, 1'b0, 2);
    do_req("t4.sat",   20'h04000, 3'd3, 20'hFFFFF, 1'b1, 3);
    do_req("t4.clr",   20'h00400, 3'd7, 20'h00400, 1'b0, 7);
    do_req("b.zero3",  20'h00000, 3'd3, 20'h00000, 1'b0, 3);
    do_req("b.zero0",  20'h00000, 3'd0, 20'h00400, 1'b0, 1);
    do_req("b.max1",   20'hFFFFF, 3'd1, 20'hFFFFF, 1'b0, 1);
    do_req("b.tiny",   20'h00001, 3'd2, 20'h00000, 1'b0, 2);
    do_req("b.sat2",   20'hFFFFF, 3'd2, 20'hFFFFF, 1'b1, 2);

    // Second request strobed while the first is still in CALC must be dropped.
    in_valid = 1'b1; in_base = 20'h00800; in_exp = 3'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_base = 20'h00800; in_exp = 3'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulses = 0; first_at = 0; first_data = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (pulses == 0) begin
          first_at   = i + 1;
          first_data = out_data;
        end
        pulses++;
      end
    end
    check("t5.pulses", 32'(pulses), 32'd1);
    check("t5.lat", 32'(first_at), 32'd1);
    check("t5.data", 32'(first_data), 32'h02000);

    do_req("t5.b2b_a", 20'h00C00, 3'd2, 20'h02400, 1'b0, 2);
    do_req("t5.b2b_b", 20'h00800, 3'd1, 20'h00800, 1'b0, 1);

    // Reset mid-CALC aborts the transaction.
    in_valid = 1'b1; in_base = 20'h00800; in_exp = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6.rst_outs", {11'd0, out_valid, out_ovf, out_data}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid || out_ovf || (out_data != '0)) pulses++;
    end
    check("t6.no_out", 32'(pulses), 32'd0);
    do_req("t6.after", 20'h00C00, 3'd2, 20'h02400, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
